// File: rtl/ud_counter_pkg.sv
// Shared constants for the modulo up/down counter.
// Direction encoding used on the M input; deliberately free of width-dependent types.
package ud_counter_pkg;

  localparam logic COUNT_UP   = 1'b0;
  localparam logic COUNT_DOWN = 1'b1;

endpackage

// File: rtl/ud_next_state.sv
// Combinational next-count, terminal-count and wrap-event logic for mod_up_down_counter.
// Compile option SATURATE_MODE_EN: terminal-count steps hold Q instead of wrapping.
module ud_next_state
  import ud_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_d,
  output logic             tc,
  output logic             wrap_d
);

  // MODULUS may equal 2^WIDTH, so the top count is the largest constant that fits.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  always_comb begin
    tc     = (m == COUNT_UP) ? (q == MAX_Q) : (q == '0);
    q_d    = q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = (d > MAX_Q) ? MAX_Q : d;
    end else if (en) begin
      wrap_d = tc;
      if (tc) begin
`ifdef SATURATE_MODE_EN
        q_d = q;
`else
        q_d = (m == COUNT_UP) ? '0 : MAX_Q;
`endif
      end else begin
        q_d = (m == COUNT_UP) ? q + ONE : q - ONE;
      end
    end
  end

endmodule

// File: rtl/mod_up_down_counter.sv
// Modulo-MODULUS up/down counter with parallel load, terminal count and wrap pulse.
// Compile option SATURATE_MODE_EN (handled in ud_next_state) selects saturation over wrap.
module mod_up_down_counter
  import ud_counter_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             M,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Wrap
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;

  ud_next_state #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q     (q_q),
    .en    (En),
    .m     (M),
    .load  (Load),
    .d     (D),
    .q_d   (q_d),
    .tc    (Tc),
    .wrap_d(wrap_d)
  );

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = q_q;
  assign Wrap = wrap_q;

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Self-checking bench for mod_up_down_counter: arithmetic reference model plus directed literals.
// Build with SATURATE_MODE_EN defined to exercise the saturating variant (MODULUS=8).
module tb_mod_up_down_counter;

  localparam int WIDTH = 3;
`ifdef SATURATE_MODE_EN
  localparam int MOD = 8;
  localparam bit SAT = 1'b1;
`else
  localparam int MOD = 6;
  localparam bit SAT = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Clr = 1'b0;
  logic             En = 1'b0;
  logic             M = 1'b0;
  logic             Load = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic [WIDTH-1:0] Q;
  logic             Tc;
  logic             Wrap;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  int mq = 0;
  int mw = 0;

  mod_up_down_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .En  (En),
    .M   (M),
    .Load(Load),
    .D   (D),
    .Q   (Q),
    .Tc  (Tc),
    .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  function automatic int model_tc(input int q, input logic dir);
    return ((dir == 1'b0 && q == MOD - 1) || (dir == 1'b1 && q == 0)) ? 1 : 0;
  endfunction

  // Reference model: plain modulo arithmetic on integers.
  always @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      mq <= 0;
      mw <= 0;
    end else if (Load) begin
      mq <= (int'(D) >= MOD) ? MOD - 1 : int'(D);
      mw <= 0;
    end else if (En) begin
      mw <= model_tc(mq, M);
      if (M == 1'b0)
        mq <= (SAT && mq == MOD - 1) ? mq : (mq + 1) % MOD;
      else
        mq <= (SAT && mq == 0) ? mq : (mq - 1 + MOD) % MOD;
    end else begin
      mw <= 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      check("model_q", int'(Q), mq);
      check("model_wrap", int'(Wrap), mw);
      check("model_tc", int'(Tc), model_tc(mq, M));
    end
  end

  task automatic drive(input logic l, input logic e, input logic mm, input int dd);
    Load = l;
    En   = e;
    M    = mm;
    D    = WIDTH'(dd);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_q[12];
    int exp_w[12];
    exp_q = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
    exp_w = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

    #2;
    check("reset_q", int'(Q), 0);
    check("reset_wrap", int'(Wrap), 0);
    tick();
    #3;
    Clr = 1'b1;
    chk_on = 1'b1;
    tick();

`ifndef SATURATE_MODE_EN
    // Twelve up-count edges from zero, wrapping at 5.
    drive(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up_q", int'(Q), exp_q[i]);
      check("up_wrap", int'(Wrap), exp_w[i]);
    end

    // Down from zero: Tc only while Q is 0.
    drive(1'b0, 1'b1, 1'b1, 0);
    #1;
    check("down_tc_at0", int'(Tc), 1);
    tick();
    check("down_q0", int'(Q), 5);
    check("down_wrap0", int'(Wrap), 1);
    check("down_tc0", int'(Tc), 0);
    tick();
    check("down_q1", int'(Q), 4);
    check("down_wrap1", int'(Wrap), 0);
    tick();
    check("down_q2", int'(Q), 3);
    check("down_tc2", int'(Tc), 0);

    // Hold at 3 while M toggles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, logic'(i % 2), 0);
      tick();
      check("hold_q", int'(Q), 3);
      check("hold_wrap", int'(Wrap), 0);
      check("hold_tc", int'(Tc), 0);
    end

    // Load clamps out-of-range D; load at terminal count gives no wrap.
    drive(1'b1, 1'b1, 1'b0, 7);
    tick();
    check("load_clamp_q", int'(Q), 5);
    check("load_clamp_wrap", int'(Wrap), 0);
    check("load_tc", int'(Tc), 1);
    drive(1'b1, 1'b1, 1'b0, 2);
    tick();
    check("load2_q", int'(Q), 2);
    check("load2_wrap", int'(Wrap), 0);

    // Async clear mid-count at Q=5.
    drive(1'b1, 1'b0, 1'b0, 4);
    tick();
    drive(1'b0, 1'b1, 1'b0, 0);
    tick();
    check("pre_clr_q", int'(Q), 5);
    #1 Clr = 1'b0;
    #1;
    check("async_clr_q", int'(Q), 0);
    check("async_clr_wrap", int'(Wrap), 0);
    #1 Clr = 1'b1;
    tick();
    check("post_clr_q", int'(Q), 1);

    // Clear while a wrap pulse is high.
    drive(1'b1, 1'b0, 1'b0, 5);
    tick();
    drive(1'b0, 1'b1, 1'b0, 0);
    tick();
    check("wrap_before_clr", int'(Wrap), 1);
    #1 Clr = 1'b0;
    #1;
    check("clr_kills_wrap", int'(Wrap), 0);
    #1 Clr = 1'b1;
    tick();
`else
    // Up saturation at 7.
    drive(1'b1, 1'b0, 1'b0, 6);
    tick();
    drive(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_up_q", int'(Q), 7);
      check("sat_up_wrap", int'(Wrap), (i == 0) ? 0 : 1);
    end
    // Down saturation at 0.
    drive(1'b1, 1'b0, 1'b1, 1);
    tick();
    drive(1'b0, 1'b1, 1'b1, 0);
    tick();
    check("sat_dn_q0", int'(Q), 0);
    check("sat_dn_wrap0", int'(Wrap), 0);
    tick();
    check("sat_dn_q1", int'(Q), 0);
    check("sat_dn_wrap1", int'(Wrap), 1);
    check("sat_dn_tc", int'(Tc), 1);
    // Async clear.
    #1 Clr = 1'b0;
    #1;
    check("async_clr_q", int'(Q), 0);
    check("async_clr_wrap", int'(Wrap), 0);
    #1 Clr = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 0);
    tick();
    check("post_clr_q", int'(Q), 1);
`endif

    // Mixed directed pattern, checked by the model each cycle.
    for (int i = 0; i < 40; i++) begin
      drive(logic'((i % 11) == 7), logic'((i % 5) != 3), logic'((i / 6) % 2), (i * 3) % 8);
      tick();
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
